// File: rtl/polygon_edge_sequencer_pkg.sv
// Shared types and defaults for the polygon edge sequencer and its vertex mux.
package polygon_edge_sequencer_pkg;

  localparam int COORD_W_DEF = 10;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } point2d_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR_REQ,
    CLR_WAIT,
    SETUP,
    DRAW,
    NEXT,
    DONE,
    ERR
  } seq_state_t;

endpackage

// File: rtl/polygon_edge_sequencer_vertex_mux.sv
// Combinational selector: returns vertex idx from packed X/Y coordinate buses.
module polygon_edge_sequencer_vertex_mux #(
  parameter int MAX_VERTS = 8,
  parameter int COORD_W   = 10,
  parameter int VIDX_W    = $clog2(MAX_VERTS + 1)
) (
  input  logic [MAX_VERTS*COORD_W-1:0] vert_x,
  input  logic [MAX_VERTS*COORD_W-1:0] vert_y,
  input  logic [VIDX_W-1:0]            idx,
  output logic [COORD_W-1:0]           x,
  output logic [COORD_W-1:0]           y
);

  // Out-of-range indices yield zero rather than an undefined slice.
  always_comb begin
    x = '0;
    y = '0;
    for (int k = 0; k < MAX_VERTS; k++) begin
      if (idx == VIDX_W'(k)) begin
        x = vert_x[k*COORD_W +: COORD_W];
        y = vert_y[k*COORD_W +: COORD_W];
      end
    end
  end

endmodule

// File: rtl/polygon_edge_sequencer.sv
// Walks an N-vertex polygon or polyline and issues one line-draw request per edge,
// optionally preceded by a framebuffer-clear handshake.
module polygon_edge_sequencer
  import polygon_edge_sequencer_pkg::*;
#(
  parameter int MAX_VERTS = 8,
  parameter int COORD_W   = COORD_W_DEF,
  localparam int VIDX_W   = $clog2(MAX_VERTS + 1)
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         start,
  input  logic [MAX_VERTS*COORD_W-1:0] vert_x,
  input  logic [MAX_VERTS*COORD_W-1:0] vert_y,
  input  logic [VIDX_W-1:0]            vert_count,
  input  logic                         closed,
  input  logic                         clear_en,
  input  logic                         clear_done,
  input  logic                         line_done,
  output logic [COORD_W-1:0]           p_x,
  output logic [COORD_W-1:0]           p_y,
  output logic [COORD_W-1:0]           q_x,
  output logic [COORD_W-1:0]           q_y,
  output logic                         line_start,
  output logic                         clear_start,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  // Handshakes: start is a one-cycle request accepted only in IDLE; done (with
  // error for a bad count) is the one-cycle reply. line_start/clear_start are
  // one-cycle requests; line_done/clear_done are honoured only in DRAW/CLR_WAIT.
  seq_state_t state, state_nxt;

  logic [MAX_VERTS*COORD_W-1:0] vx_q, vy_q, src_x, src_y;
  logic [VIDX_W-1:0]            count_q, cnt_src, idx, idx_inc;
  logic [VIDX_W-1:0]            sel_p, sel_p_inc, sel_q, edges;
  logic                         closed_q, illegal;
  logic [COORD_W-1:0]           px_sel, py_sel, qx_sel, qy_sel;

  assign illegal = (vert_count < VIDX_W'(2)) || (vert_count > VIDX_W'(MAX_VERTS));
  assign idx_inc = idx + VIDX_W'(1);

  // A 2-vertex closed shape has only one distinct edge.
  assign edges = closed_q ? ((count_q == VIDX_W'(2)) ? VIDX_W'(1) : count_q)
                          : count_q - VIDX_W'(1);

  // The SETUP entered straight from IDLE must see the raw inputs, since the
  // latches load on that same edge.
  assign src_x   = (state == IDLE) ? vert_x     : vx_q;
  assign src_y   = (state == IDLE) ? vert_y     : vy_q;
  assign cnt_src = (state == IDLE) ? vert_count : count_q;

  always_comb begin
    sel_p     = (state == NEXT) ? idx_inc : '0;
    sel_p_inc = sel_p + VIDX_W'(1);
    sel_q     = (sel_p_inc == cnt_src) ? '0 : sel_p_inc;
  end

  polygon_edge_sequencer_vertex_mux #(
    .MAX_VERTS(MAX_VERTS), .COORD_W(COORD_W), .VIDX_W(VIDX_W)
  ) u_mux_p (
    .vert_x(src_x), .vert_y(src_y), .idx(sel_p), .x(px_sel), .y(py_sel)
  );

  polygon_edge_sequencer_vertex_mux #(
    .MAX_VERTS(MAX_VERTS), .COORD_W(COORD_W), .VIDX_W(VIDX_W)
  ) u_mux_q (
    .vert_x(src_x), .vert_y(src_y), .idx(sel_q), .x(qx_sel), .y(qy_sel)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (illegal)       state_nxt = ERR;
          else if (clear_en) state_nxt = CLR_REQ;
          else               state_nxt = SETUP;
        end
      end
      CLR_REQ:  state_nxt = CLR_WAIT;
      CLR_WAIT: if (clear_done) state_nxt = SETUP;
      SETUP:    state_nxt = DRAW;
      DRAW:     if (line_done) state_nxt = NEXT;
      NEXT:     state_nxt = (idx_inc == edges) ? DONE : SETUP;
      DONE:     state_nxt = IDLE;
      ERR:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      vx_q     <= '0;
      vy_q     <= '0;
      count_q  <= '0;
      closed_q <= 1'b0;
      idx      <= '0;
      p_x      <= '0;
      p_y      <= '0;
      q_x      <= '0;
      q_y      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        vx_q     <= vert_x;
        vy_q     <= vert_y;
        count_q  <= vert_count;
        closed_q <= closed;
        idx      <= '0;
      end else if (state == NEXT && state_nxt == SETUP) begin
        idx <= idx_inc;
      end
      // Endpoints are registered on entry to SETUP and held until the next one.
      if (state_nxt == SETUP) begin
        p_x <= px_sel;
        p_y <= py_sel;
        q_x <= qx_sel;
        q_y <= qy_sel;
      end
    end
  end

  assign line_start  = (state == SETUP);
  assign clear_start = (state == CLR_REQ);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE) || (state == ERR);
  assign error       = (state == ERR);

endmodule

// File: doc/polygon_edge_sequencer.md
Name: polygon_edge_sequencer

Overview:
- Parametrised successor to the triangle rasterizer controller. Walks an N-vertex polygon, fixed at MAX_VERTS capacity, and issues one line-draw request per edge to the Bresenham line engine over a start/done handshake.
- Adds the following over a fixed triangle:
  - a run-time vertex count,
  - an open-polyline or closed-polygon mode,
  - an optional framebuffer-clear handshake,
  - input latching,
  - error reporting for an illegal vertex count.
- Sits between the geometry front-end and the line engine.

Parameters:
- MAX_VERTS, 8, maximum vertices per polygon; must be ≥ 2.
- COORD_W, 10, bits per X/Y coordinate. Default comes from package constant COORD_W_DEF.
- VIDX_W, $clog2(MAX_VERTS+1), width of vertex count and index. Derived; not overridden.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- vert_x  in  MAX_VERTS*COORD_W  packed X coordinates; vertex k occupies [k*COORD_W +: COORD_W].
- vert_y  in  MAX_VERTS*COORD_W  packed Y coordinates, same layout as vert_x.
- vert_count  in  VIDX_W  number of valid vertices.
- closed  in  1  1 = also draw the edge from the last vertex back to vertex 0.
- clear_en  in  1  1 = run the clear handshake before drawing.
- clear_done  in  1  clear engine finished; sampled only in CLR_WAIT.
- line_done  in  1  line engine finished; sampled only in DRAW.
- p_x, p_y  out  COORD_W each  edge start point.
- q_x, q_y  out  COORD_W each  edge end point.
- line_start  out  1  one-cycle line request.
- clear_start  out  1  one-cycle clear request.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse, coincident with done, for an illegal vertex count.

Behaviour:

Reset (async) and defaults:
- State goes to IDLE.
- All outputs reset to 0: p_x, p_y, q_x, q_y, line_start, clear_start, busy, done, error.
- Edge index and all latched registers reset to 0.
- Reset mid-operation aborts immediately; no done pulse is issued.

States: IDLE, CLR_REQ, CLR_WAIT, SETUP, DRAW, NEXT, DONE, ERR.

Transitions:
- IDLE, start=1:
  - Latch vert_x, vert_y, vert_count, closed and clear_en.
  - Set edge index i = 0.
  - If vert_count < 2 or vert_count > MAX_VERTS, go to ERR.
  - Else if clear_en, go to CLR_REQ.
  - Else go to SETUP.
- CLR_REQ: clear_start = 1 for this one cycle; go to CLR_WAIT.
- CLR_WAIT: stay until clear_done = 1, then go to SETUP.
- SETUP:
  - line_start = 1 for this one cycle.
  - p = v[i] and q = v[(i+1 == count) ? 0 : i+1]. Both are registered and loaded on entry to SETUP, so they are valid in the SETUP cycle.
  - Go to DRAW.
- DRAW:
  - p/q are held stable.
  - Stay until line_done = 1, then go to NEXT.
- NEXT:
  - Edges to draw: E = closed ? count : count-1. Special case: if count == 2 and closed, E = 1 (no duplicate reverse edge).
  - If i+1 == E, go to DONE.
  - Else i ← i+1 and go to SETUP.
- DONE: done = 1 for one cycle; go to IDLE.
- ERR: done = 1 and error = 1 for one cycle; go to IDLE. No line or clear request is ever issued for an illegal count.

Outputs and timing:
- Control outputs are Moore, decoded from registered state:
  - line_start = (state == SETUP)
  - clear_start = (state == CLR_REQ)
  - busy = (state != IDLE)
- p/q retain their last values after DONE.
- Latency (no clear):
  - start at cycle t → line_start at t+1.
  - Each edge costs 3 cycles (SETUP, DRAW, NEXT) plus the time until line_done.
  - done arrives 2 cycles after the final line_done (NEXT, then DONE).

Boundary conditions:
- start while busy: ignored. The latched inputs stay unchanged.
- line_done or clear_done outside its sampling state: ignored.
- line_done high in the first DRAW cycle is accepted, giving a minimum 3-cycle edge.
- Changes to inputs after start has been latched have no effect on the current polygon.
- Index arithmetic uses VIDX_W bits. The wrap to vertex 0 is an explicit compare, never a modulo operator.

Decomposition:
- defines_package additions:
  - COORD_W_DEF = 10.
  - The Point2D struct {x, y}, sized by COORD_W_DEF.
  - A SeqState enum with the eight states above.
- Sub-module vertex_mux: combinational. Selects vertex k (VIDX_W-bit index) from packed vert_x/vert_y and is instantiated twice, for p and q. It is parametrised by MAX_VERTS and COORD_W.
- The FSM, latches and index counter stay in polygon_edge_sequencer.

Test Plan:
- Triangle, closed=1, clear_en=0, count=3, vertices (0,0), (10,0), (0,10); line_done 4 cycles after each line_start → edges issued in order (0,0)→(10,0), (10,0)→(0,10), (0,10)→(0,0). Exactly 3 line_start pulses; done 2 cycles after the 3rd line_done; error=0.
- Open polyline, count=4, closed=0, vertices (1,1), (2,2), (3,3), (4,4) → exactly 3 edges, with the last edge (3,3)→(4,4); no closing edge.
- clear_en=1, count=2, closed=1, clear_done held off 10 cycles → clear_start pulses exactly once at t+1; no line_start until after clear_done; exactly 1 edge (v0→v1); then done.
- Illegal counts: count=1, count=0, and count=MAX_VERTS+1 → error and done both high one cycle at t+1; line_start and clear_start never asserted.
- Robustness: during DRAW, assert start and change vert_x, and pulse line_done while in SETUP → p/q unchanged, no restart, the SETUP pulse is ignored. Then drop n_rst mid-DRAW → all outputs 0 immediately and the FSM in IDLE; a new start after reset runs normally.
- Full capacity: count=MAX_VERTS=8, closed=1 → 8 edges, the last being v7→v0; busy high from t+1 until the cycle after done.
